control_gw_to_network_bridge: RTL and testbench
===============================================

Name: control_gw_to_network_bridge

Overview:
- Transmit-side control gateway. Takes single-beat control messages from the control block and emits two-beat packets to the network bridge.
- Each packet is a header beat followed by the control payload beat (payload beat carries tlast).
- It is the counterpart of the receive-side gateway, which discards the header beat and forwards only the tlast beat to control.
- Registered outputs. Sustains one message every 2 cycles, which is full output bandwidth.

Parameters:
- AXIS_DATA_WIDTH, 64, data width of both streams; must be >= 64.
- AXIS_KEEP_WIDTH, 8, AXIS_DATA_WIDTH/8.
- IP_PORT_WIDTH, 16, UDP/TCP port width (tid, tdest).
- IP_ADDRESS_WIDTH, 32, IPv4 address width (tuser).
- COUNT_WIDTH, 32, width of the status counters.

Ports:
- i_clk  in  1  clock
- i_ap_rst_n  in  1  synchronous active-low reset
- from_ctrl_tvalid  in  1  control message valid
- from_ctrl_tready  out  1  control message accepted
- from_ctrl_tdata  in  AXIS_DATA_WIDTH  control payload
- from_ctrl_tkeep  in  AXIS_KEEP_WIDTH  payload byte enables
- from_ctrl_tid  in  IP_PORT_WIDTH  source port
- from_ctrl_tdest  in  IP_PORT_WIDTH  destination port
- from_ctrl_tuser  in  IP_ADDRESS_WIDTH  destination IP
- from_ctrl_tlast  in  1  ignored; every beat is one message
- to_network_bridge_tvalid  out  1  beat valid
- to_network_bridge_tready  in  1  bridge ready
- to_network_bridge_tdata  out  AXIS_DATA_WIDTH  header or payload
- to_network_bridge_tkeep  out  AXIS_KEEP_WIDTH  byte enables
- to_network_bridge_tid  out  IP_PORT_WIDTH  captured tid
- to_network_bridge_tdest  out  IP_PORT_WIDTH  captured tdest
- to_network_bridge_tuser  out  IP_ADDRESS_WIDTH  captured tuser
- to_network_bridge_tlast  out  1  high on payload beat only
- o_msg_count  out  COUNT_WIDTH  payload beats sent
- o_drop_count  out  COUNT_WIDTH  messages dropped for tkeep==0

Behaviour:
- Clock and reset: single clock i_clk; synchronous active-low reset i_ap_rst_n.
- Reset values: all outputs 0, state IDLE, both counters 0, capture register cleared.
- Reset mid-packet: any in-flight message is discarded and no further beats of it are emitted.
- States:
  - IDLE: no output valid.
  - HDR: header beat valid.
  - PAY: payload beat valid.
- Ready rule: from_ctrl_tready = (state==IDLE) | (state==PAY & to_network_bridge_tready). Combinational from state and tready only; independent of from_ctrl_tvalid.
- Accept: when from_ctrl_tvalid & from_ctrl_tready, capture tdata, tkeep, tid, tdest, tuser.
  - If the captured tkeep != 0, next state is HDR.
  - If tkeep == 0, the message is dropped, o_drop_count increments, and next state is IDLE.
- HDR beat contents:
  - tdata[31:0] = tuser (zero-extended or truncated to 32 bits); tdata[47:32] = tdest[15:0]; tdata[63:48] = tid[15:0]; upper bits 0.
  - tkeep all ones; tlast = 0.
  - Handshake moves to PAY.
- PAY beat: tdata and tkeep as captured; tlast = 1.
  - Handshake increments o_msg_count.
  - Next state is HDR if a new message is accepted in the same cycle (tkeep != 0), otherwise IDLE.
- Sideband: tid/tdest/tuser hold the captured values on both beats.
- Output hold: while valid and not ready, every output field stays stable.
- Latency: message accepted in cycle N gives header valid in cycle N+1 and payload valid in cycle N+2 (with bridge always ready).
- Throughput: back-to-back messages produce header/payload alternating with no bubble.
- Counters wrap modulo 2^COUNT_WIDTH.
- Simultaneous events: drop and send in the same cycle update separate counters independently.

Decomposition:
- Shared package ctrl_gw_pkg holds:
  - state enum {IDLE, HDR, PAY}
  - header field offsets (HDR_IP_LSB=0, HDR_DPORT_LSB=32, HDR_SPORT_LSB=48)
  - HDR_WIDTH=64
- Widths come from ctrl_api_header_parameters.vh.
- One natural sub-module: ctrl_gw_hdr_pack, purely combinational, mapping (tuser, tdest, tid) to the header tdata.

Test Plan:
1. Single message: tdata=0xDEADBEEF, tkeep=0x0F, tid=0x1234, tdest=0x5678, tuser=0x0A000001, bridge always ready → header tdata=0x1234_5678_0A000001 with tlast=0 at N+1; payload 0xDEADBEEF with tkeep=0x0F and tlast=1 at N+2; o_msg_count=1.
2. Back-to-back: 4 messages with source always valid and bridge always ready → 8 beats with no bubbles; tready low only in HDR cycles; o_msg_count=4.
3. Backpressure: bridge tready low for 5 cycles during HDR, then during PAY → outputs held stable; from_ctrl_tready=0 throughout the stalls; no loss or duplication.
4. Zero keep: message with tkeep=0 → no output beats; o_drop_count=1; o_msg_count unchanged; the next valid message is sent normally.
5. Reset mid-packet: assert i_ap_rst_n=0 in PAY for 1 cycle → tvalid=0 the next cycle; counters=0; the aborted payload is never emitted.
6. Wrap: preload o_msg_count to 0xFFFFFFFF by force, send 1 message → o_msg_count=0.

Source files
------------

// File: rtl/ctrl_gw_pkg.sv
// Shared definitions for the transmit-side control gateway.
// Holds the packet state encoding and the header field layout.
package ctrl_gw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } state_t;

  localparam int HDR_IP_LSB    = 0;
  localparam int HDR_DPORT_LSB = 32;
  localparam int HDR_SPORT_LSB = 48;
  localparam int HDR_WIDTH     = 64;

endpackage

// File: rtl/ctrl_gw_hdr_pack.sv
// Combinational packer building the header beat from the message sideband.
// Header layout: source port, destination port, destination IP (MSB to LSB).
module ctrl_gw_hdr_pack
  import ctrl_gw_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int IP_PORT_WIDTH    = 16,
  parameter int IP_ADDRESS_WIDTH = 32
) (
  input  logic [IP_ADDRESS_WIDTH-1:0] tuser,
  input  logic [IP_PORT_WIDTH-1:0]    tdest,
  input  logic [IP_PORT_WIDTH-1:0]    tid,
  output logic [AXIS_DATA_WIDTH-1:0]  hdr
);

  logic [HDR_WIDTH-1:0] hdr_core;

  // Each field is resized to its fixed slot, so odd port/IP widths still land correctly.
  always_comb begin
    hdr_core = '0;
    hdr_core[HDR_IP_LSB +: 32]    = 32'(tuser);
    hdr_core[HDR_DPORT_LSB +: 16] = 16'(tdest);
    hdr_core[HDR_SPORT_LSB +: 16] = 16'(tid);
    hdr = AXIS_DATA_WIDTH'(hdr_core);
  end

endmodule

// File: rtl/control_gw_to_network_bridge.sv
// Transmit-side control gateway: turns single-beat control messages into
// header + payload packets for the network bridge, with status counters.
module control_gw_to_network_bridge
  import ctrl_gw_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = 8,
  parameter int IP_PORT_WIDTH    = 16,
  parameter int IP_ADDRESS_WIDTH = 32,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                        i_clk,
  input  logic                        i_ap_rst_n,
  input  logic                        from_ctrl_tvalid,
  output logic                        from_ctrl_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_ctrl_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_ctrl_tkeep,
  input  logic [IP_PORT_WIDTH-1:0]    from_ctrl_tid,
  input  logic [IP_PORT_WIDTH-1:0]    from_ctrl_tdest,
  input  logic [IP_ADDRESS_WIDTH-1:0] from_ctrl_tuser,
  input  logic                        from_ctrl_tlast,
  output logic                        to_network_bridge_tvalid,
  input  logic                        to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  to_network_bridge_tkeep,
  output logic [IP_PORT_WIDTH-1:0]    to_network_bridge_tid,
  output logic [IP_PORT_WIDTH-1:0]    to_network_bridge_tdest,
  output logic [IP_ADDRESS_WIDTH-1:0] to_network_bridge_tuser,
  output logic                        to_network_bridge_tlast,
  output logic [COUNT_WIDTH-1:0]      o_msg_count,
  output logic [COUNT_WIDTH-1:0]      o_drop_count
);

  state_t                     state;
  logic [AXIS_DATA_WIDTH-1:0] cap_data;
  logic [AXIS_KEEP_WIDTH-1:0] cap_keep;
  logic [AXIS_DATA_WIDTH-1:0] hdr_word;
  logic                       accept;
  logic                       accept_keep;
  logic                       accept_drop;
  logic                       unused_tlast;

  assign unused_tlast = from_ctrl_tlast;

  ctrl_gw_hdr_pack #(
    .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
    .IP_PORT_WIDTH   (IP_PORT_WIDTH),
    .IP_ADDRESS_WIDTH(IP_ADDRESS_WIDTH)
  ) u_hdr_pack (
    .tuser(from_ctrl_tuser),
    .tdest(from_ctrl_tdest),
    .tid  (from_ctrl_tid),
    .hdr  (hdr_word)
  );

  // A new message may enter while the payload beat leaves, giving gap-free packets.
  assign from_ctrl_tready = (state == IDLE) | ((state == PAY) & to_network_bridge_tready);
  assign accept           = from_ctrl_tvalid & from_ctrl_tready;
  assign accept_keep      = accept & (|from_ctrl_tkeep);
  assign accept_drop      = accept & ~(|from_ctrl_tkeep);

  // The header is registered straight from the inputs; the payload waits in the capture regs.
  always_ff @(posedge i_clk) begin
    if (!i_ap_rst_n) begin
      state                    <= IDLE;
      cap_data                 <= '0;
      cap_keep                 <= '0;
      to_network_bridge_tvalid <= 1'b0;
      to_network_bridge_tdata  <= '0;
      to_network_bridge_tkeep  <= '0;
      to_network_bridge_tid    <= '0;
      to_network_bridge_tdest  <= '0;
      to_network_bridge_tuser  <= '0;
      to_network_bridge_tlast  <= 1'b0;
      o_msg_count              <= '0;
      o_drop_count             <= '0;
    end else begin
      if (accept) begin
        cap_data <= from_ctrl_tdata;
        cap_keep <= from_ctrl_tkeep;
      end
      if (accept_drop) o_drop_count <= o_drop_count + COUNT_WIDTH'(1);

      case (state)
        IDLE: begin
          if (accept_keep) begin
            state                    <= HDR;
            to_network_bridge_tvalid <= 1'b1;
            to_network_bridge_tdata  <= hdr_word;
            to_network_bridge_tkeep  <= '1;
            to_network_bridge_tlast  <= 1'b0;
            to_network_bridge_tid    <= from_ctrl_tid;
            to_network_bridge_tdest  <= from_ctrl_tdest;
            to_network_bridge_tuser  <= from_ctrl_tuser;
          end
        end
        HDR: begin
          if (to_network_bridge_tready) begin
            state                   <= PAY;
            to_network_bridge_tdata <= cap_data;
            to_network_bridge_tkeep <= cap_keep;
            to_network_bridge_tlast <= 1'b1;
          end
        end
        PAY: begin
          if (to_network_bridge_tready) begin
            o_msg_count <= o_msg_count + COUNT_WIDTH'(1);
            if (accept_keep) begin
              state                    <= HDR;
              to_network_bridge_tvalid <= 1'b1;
              to_network_bridge_tdata  <= hdr_word;
              to_network_bridge_tkeep  <= '1;
              to_network_bridge_tlast  <= 1'b0;
              to_network_bridge_tid    <= from_ctrl_tid;
              to_network_bridge_tdest  <= from_ctrl_tdest;
              to_network_bridge_tuser  <= from_ctrl_tuser;
            end else begin
              state                    <= IDLE;
              to_network_bridge_tvalid <= 1'b0;
              to_network_bridge_tlast  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_gw_to_network_bridge.sv
// Directed self-checking bench for the transmit-side control gateway.
module tb_control_gw_to_network_bridge;

  logic        clk;
  logic        rst_n;
  logic        src_valid;
  logic        src_ready;
  logic [63:0] src_data;
  logic [7:0]  src_keep;
  logic [15:0] src_tid;
  logic [15:0] src_tdest;
  logic [31:0] src_tuser;
  logic        src_last;
  logic        net_valid;
  logic        net_ready;
  logic [63:0] net_data;
  logic [7:0]  net_keep;
  logic [15:0] net_tid;
  logic [15:0] net_tdest;
  logic [31:0] net_tuser;
  logic        net_last;
  logic [31:0] msg_count;
  logic [31:0] drop_count;

  int compared   = 0;
  int mismatched = 0;

  control_gw_to_network_bridge dut (
    .i_clk                   (clk),
    .i_ap_rst_n              (rst_n),
    .from_ctrl_tvalid        (src_valid),
    .from_ctrl_tready        (src_ready),
    .from_ctrl_tdata         (src_data),
    .from_ctrl_tkeep         (src_keep),
    .from_ctrl_tid           (src_tid),
    .from_ctrl_tdest         (src_tdest),
    .from_ctrl_tuser         (src_tuser),
    .from_ctrl_tlast         (src_last),
    .to_network_bridge_tvalid(net_valid),
    .to_network_bridge_tready(net_ready),
    .to_network_bridge_tdata (net_data),
    .to_network_bridge_tkeep (net_keep),
    .to_network_bridge_tid   (net_tid),
    .to_network_bridge_tdest (net_tdest),
    .to_network_bridge_tuser (net_tuser),
    .to_network_bridge_tlast (net_last),
    .o_msg_count             (msg_count),
    .o_drop_count            (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [7:0] k,
                               input logic [15:0] id, input logic [15:0] dst, input logic [31:0] ip);
    src_valid = v;
    src_data  = d;
    src_keep  = k;
    src_tid   = id;
    src_tdest = dst;
    src_tuser = ip;
    src_last  = v;
  endtask

  task automatic idleSource();
    applyStimulus(1'b0, 64'h0, 8'h0, 16'h0, 16'h0, 32'h0);
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] msgData(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
  endfunction
  function automatic logic [7:0]  msgKeep(input int i);
    return 8'hFF >> i;
  endfunction
  function automatic logic [15:0] msgTid(input int i);
    return 16'h0100 + 16'(i);
  endfunction
  function automatic logic [15:0] msgDest(input int i);
    return 16'h0200 + 16'(i);
  endfunction
  function automatic logic [31:0] msgIp(input int i);
    return 32'hC0A8_0000 + 32'(i);
  endfunction

  task automatic sendTableMsg(input int i);
    applyStimulus(1'b1, msgData(i), msgKeep(i), msgTid(i), msgDest(i), msgIp(i));
  endtask

  initial begin
    logic [31:0] exp_msg;
    rst_n     = 1'b0;
    net_ready = 1'b1;
    idleSource();
    repeat (3) nextCycle();
    checkOutput("reset_valid", 64'(net_valid), 64'h0);
    checkOutput("reset_data", net_data, 64'h0);
    checkOutput("reset_last", 64'(net_last), 64'h0);
    checkOutput("reset_msg_count", 64'(msg_count), 64'h0);
    checkOutput("reset_drop_count", 64'(drop_count), 64'h0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("idle_ready", 64'(src_ready), 64'h1);

    // Single message with fixed latency.
    $display("[TB] single message");
    applyStimulus(1'b1, 64'hDEADBEEF, 8'h0F, 16'h1234, 16'h5678, 32'h0A000001);
    nextCycle();
    idleSource();
    checkOutput("t1_hdr_valid", 64'(net_valid), 64'h1);
    checkOutput("t1_hdr_data", net_data, 64'h1234_5678_0A00_0001);
    checkOutput("t1_hdr_keep", 64'(net_keep), 64'hFF);
    checkOutput("t1_hdr_last", 64'(net_last), 64'h0);
    checkOutput("t1_hdr_tid", 64'(net_tid), 64'h1234);
    checkOutput("t1_hdr_ready", 64'(src_ready), 64'h0);
    nextCycle();
    checkOutput("t1_pay_valid", 64'(net_valid), 64'h1);
    checkOutput("t1_pay_data", net_data, 64'hDEADBEEF);
    checkOutput("t1_pay_keep", 64'(net_keep), 64'h0F);
    checkOutput("t1_pay_last", 64'(net_last), 64'h1);
    checkOutput("t1_pay_tuser", 64'(net_tuser), 64'h0A000001);
    checkOutput("t1_pay_tdest", 64'(net_tdest), 64'h5678);
    nextCycle();
    checkOutput("t1_after_valid", 64'(net_valid), 64'h0);
    checkOutput("t1_msg_count", 64'(msg_count), 64'h1);
    exp_msg = 32'd1;

    // Back-to-back: cycle c=0 is IDLE, odd c is a header, even c>0 a payload.
    $display("[TB] back-to-back");
    for (int c = 0; c <= 9; c++) begin
      if (c / 2 < 4) sendTableMsg(c / 2);
      else idleSource();
      #1;
      checkOutput($sformatf("t2_valid_c%0d", c), 64'(net_valid), 64'((c >= 1) && (c <= 8)));
      checkOutput($sformatf("t2_ready_c%0d", c), 64'(src_ready), 64'(!((c % 2 == 1) && (c <= 7))));
      if (c >= 1 && c <= 8) begin
        if (c % 2 == 1) begin
          checkOutput($sformatf("t2_hdr_c%0d", c), net_data,
                      {msgTid((c - 1) / 2), msgDest((c - 1) / 2), msgIp((c - 1) / 2)});
          checkOutput($sformatf("t2_hlast_c%0d", c), 64'(net_last), 64'h0);
        end else begin
          checkOutput($sformatf("t2_pay_c%0d", c), net_data, msgData(c / 2 - 1));
          checkOutput($sformatf("t2_pkeep_c%0d", c), 64'(net_keep), 64'(msgKeep(c / 2 - 1)));
          checkOutput($sformatf("t2_plast_c%0d", c), 64'(net_last), 64'h1);
        end
      end
      nextCycle();
    end
    exp_msg = exp_msg + 32'd4;
    idleSource();
    checkOutput("t2_msg_count", 64'(msg_count), 64'(exp_msg));

    // Backpressure in HDR then PAY, with a second message waiting.
    $display("[TB] backpressure");
    sendTableMsg(5);
    nextCycle();
    sendTableMsg(6);
    net_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      nextCycle();
      checkOutput($sformatf("t3_hdr_hold%0d", s), net_data, {msgTid(5), msgDest(5), msgIp(5)});
      checkOutput($sformatf("t3_hdr_valid%0d", s), 64'(net_valid), 64'h1);
      checkOutput($sformatf("t3_hdr_rdy%0d", s), 64'(src_ready), 64'h0);
    end
    net_ready = 1'b1;
    nextCycle();
    net_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      checkOutput($sformatf("t3_pay_hold%0d", s), net_data, msgData(5));
      checkOutput($sformatf("t3_pay_last%0d", s), 64'(net_last), 64'h1);
      checkOutput($sformatf("t3_pay_rdy%0d", s), 64'(src_ready), 64'h0);
      checkOutput($sformatf("t3_pay_tid%0d", s), 64'(net_tid), 64'(msgTid(5)));
      nextCycle();
    end
    net_ready = 1'b1;
    #1;
    checkOutput("t3_release_rdy", 64'(src_ready), 64'h1);
    nextCycle();
    idleSource();
    checkOutput("t3_next_hdr", net_data, {msgTid(6), msgDest(6), msgIp(6)});
    checkOutput("t3_next_hdr_last", 64'(net_last), 64'h0);
    checkOutput("t3_count_mid", 64'(msg_count), 64'(exp_msg + 32'd1));
    nextCycle();
    checkOutput("t3_next_pay", net_data, msgData(6));
    nextCycle();
    checkOutput("t3_idle_valid", 64'(net_valid), 64'h0);
    exp_msg = exp_msg + 32'd2;
    checkOutput("t3_msg_count", 64'(msg_count), 64'(exp_msg));

    // Zero keep drops in IDLE, then a drop coinciding with a payload send.
    $display("[TB] zero keep");
    applyStimulus(1'b1, 64'h55, 8'h00, 16'h1, 16'h2, 32'h3);
    nextCycle();
    idleSource();
    checkOutput("t4_drop_valid", 64'(net_valid), 64'h0);
    checkOutput("t4_drop_count", 64'(drop_count), 64'h1);
    checkOutput("t4_drop_msg", 64'(msg_count), 64'(exp_msg));
    nextCycle();
    checkOutput("t4_still_idle", 64'(net_valid), 64'h0);
    sendTableMsg(2);
    nextCycle();
    idleSource();
    checkOutput("t4_after_hdr", net_data, {msgTid(2), msgDest(2), msgIp(2)});
    nextCycle();
    checkOutput("t4_after_pay", net_data, msgData(2));
    applyStimulus(1'b1, 64'h66, 8'h00, 16'h7, 16'h8, 32'h9);
    nextCycle();
    idleSource();
    exp_msg = exp_msg + 32'd1;
    checkOutput("t4_sim_valid", 64'(net_valid), 64'h0);
    checkOutput("t4_sim_msg", 64'(msg_count), 64'(exp_msg));
    checkOutput("t4_sim_drop", 64'(drop_count), 64'h2);

    // Reset while the payload beat is presented.
    $display("[TB] reset mid-packet");
    sendTableMsg(1);
    nextCycle();
    idleSource();
    nextCycle();
    checkOutput("t5_pre_last", 64'(net_last), 64'h1);
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    checkOutput("t5_valid", 64'(net_valid), 64'h0);
    checkOutput("t5_msg_count", 64'(msg_count), 64'h0);
    checkOutput("t5_drop_count", 64'(drop_count), 64'h0);
    nextCycle();
    checkOutput("t5_no_resume", 64'(net_valid), 64'h0);
    nextCycle();
    checkOutput("t5_no_resume2", 64'(net_valid), 64'h0);
    checkOutput("t5_count_hold", 64'(msg_count), 64'h0);

    // Counter wrap.
    $display("[TB] counter wrap");
    force dut.o_msg_count = 32'hFFFF_FFFF;
    #1;
    release dut.o_msg_count;
    #1;
    checkOutput("t6_preload", 64'(msg_count), 64'hFFFF_FFFF);
    sendTableMsg(0);
    nextCycle();
    idleSource();
    nextCycle();
    checkOutput("t6_pre_wrap", 64'(msg_count), 64'hFFFF_FFFF);
    nextCycle();
    checkOutput("t6_wrapped", 64'(msg_count), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
